// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the CPU fetch and data ports.
// Data has priority, but fetch is granted after MAX_STREAK back-to-back data grants.
module mem_port_arbiter #(
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
  localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  // Handshake: a requester holds its req high until the 1-cycle ack; the memory
  // completes the access in the cycle mem_ready is high while mem_req is high.
  state_t        state, state_n;
  logic [SW-1:0] streak, streak_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          mem_req_n, mem_we_n, if_ack_n, d_ack_n, err_n;
  logic [31:0]   mem_addr_n, mem_wdata_n, if_rdata_n, d_rdata_n;
  logic          pick_d, finish, timed_out;
  logic [31:0]   read_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= '0;
      tcnt      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      streak    <= streak_n;
      tcnt      <= tcnt_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      if_rdata  <= if_rdata_n;
      d_rdata   <= d_rdata_n;
      if_ack    <= if_ack_n;
      d_ack     <= d_ack_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    streak_n    = streak;
    tcnt_n      = tcnt;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    if_rdata_n  = if_rdata;
    d_rdata_n   = d_rdata;
    if_ack_n    = 1'b0;
    d_ack_n     = 1'b0;
    err_n       = 1'b0;
    pick_d      = d_req && !(if_req && (streak == STREAK_MAX));
    timed_out   = (TIMEOUT != 0) && (tcnt == T_LAST);
    finish      = 1'b0;
    read_val    = mem_ready ? mem_rdata : 32'h0;

    case (state)
      IDLE: begin
        if (!if_req) streak_n = '0;
        if (pick_d) begin
          state_n     = BUSY_D;
          mem_req_n   = 1'b1;
          mem_we_n    = d_we;
          mem_addr_n  = d_addr;
          mem_wdata_n = d_wdata;
          tcnt_n      = '0;
          if (if_req && (streak != STREAK_MAX)) streak_n = streak + 1'b1;
        end else if (if_req) begin
          state_n     = BUSY_I;
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b0;
          mem_addr_n  = if_addr;
          mem_wdata_n = '0;
          tcnt_n      = '0;
          streak_n    = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready || timed_out) begin
          finish    = 1'b1;
          state_n   = DONE;
          mem_req_n = 1'b0;
          err_n     = !mem_ready;
        end else if (TIMEOUT != 0) begin
          tcnt_n = tcnt + 1'b1;
        end
        // A timed-out read returns zero; writes never touch the read registers.
        if (finish && (state == BUSY_I)) begin
          if_ack_n   = 1'b1;
          if_rdata_n = read_val;
        end
        if (finish && (state == BUSY_D)) begin
          d_ack_n = 1'b1;
          if (!mem_we) d_rdata_n = read_val;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
